// File: rtl/stereo_pkg.sv
// Shared constants, types and the compare-exchange helper for the disparity post-filter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: WIDTH/HEIGHT/DISP_W/ADDR_W, disparity_t, addr_t, win9_t, state_t, cas().
package stereo_pkg;

   localparam int WIDTH  = 320;
   localparam int HEIGHT = 240;
   localparam int DISP_W = 4;
   localparam int ADDR_W = 17;

   typedef logic [DISP_W-1:0] disparity_t;
   typedef logic [ADDR_W-1:0] addr_t;

   // 3x3 window, element index = column*3 + row (row 0 = top, column 0 = oldest)
   typedef logic [8:0][DISP_W-1:0] win9_t;

   typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

   // Compare-exchange: afterwards v[lo] <= v[hi]
   function automatic win9_t cas(win9_t v, logic [3:0] lo, logic [3:0] hi);
      win9_t r;
      r = v;
      if (v[lo] > v[hi]) begin
         r[lo] = v[hi];
         r[hi] = v[lo];
      end
      return r;
   endfunction

endpackage

// File: rtl/disparity_median_filter_if.sv
// Pixel-in / filtered-pixel-out bundle of the disparity median filter.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready handshake on the input side; output is a strobe with no ready.
// Ports: in_valid/in_ready/in_data/in_addr toward the filter, out_valid/out_data/out_addr/frame_done from it.
interface disparity_median_filter_if;
   import stereo_pkg::*;

   logic       in_valid;
   logic       in_ready;
   disparity_t in_data;
   addr_t      in_addr;
   logic       out_valid;
   disparity_t out_data;
   addr_t      out_addr;
   logic       frame_done;

   modport master (
      output in_valid, in_data, in_addr,
      input  in_ready, out_valid, out_data, out_addr, frame_done
   );

   modport slave (
      input  in_valid, in_data, in_addr,
      output in_ready, out_valid, out_data, out_addr, frame_done
   );
endinterface

// File: rtl/median9_sort.sv
// 19 compare-exchange median-of-9 network, split into column sorts and a final merge.
// Latency: 1 cycle (register between the two halves), free-running.
// Backpressure: none; validity is tracked by the caller alongside.
// Ports: HCLK, pix (nine window values), med (median of the values presented one cycle earlier).
module median9_sort
   import stereo_pkg::*;
(
   input  logic       HCLK,
   input  win9_t      pix,
   output disparity_t med
);

   win9_t a;
   win9_t a_q;
   win9_t b;

   // Sort each group of three (elements 0-2, 3-5, 6-8)
   always_comb begin
      a = pix;
      a = cas(a, 4'd1, 4'd2);
      a = cas(a, 4'd4, 4'd5);
      a = cas(a, 4'd7, 4'd8);
      a = cas(a, 4'd0, 4'd1);
      a = cas(a, 4'd3, 4'd4);
      a = cas(a, 4'd6, 4'd7);
      a = cas(a, 4'd1, 4'd2);
      a = cas(a, 4'd4, 4'd5);
      a = cas(a, 4'd7, 4'd8);
   end

   // Data-only pipeline register; no reset needed
   always_ff @(posedge HCLK) begin
      a_q <= a;
   end

   // Max of mins, min of maxes, median of medians, then median of those three
   always_comb begin
      b = a_q;
      b = cas(b, 4'd0, 4'd3);
      b = cas(b, 4'd5, 4'd8);
      b = cas(b, 4'd4, 4'd7);
      b = cas(b, 4'd3, 4'd6);
      b = cas(b, 4'd1, 4'd4);
      b = cas(b, 4'd2, 4'd5);
      b = cas(b, 4'd4, 4'd7);
      b = cas(b, 4'd4, 4'd2);
      b = cas(b, 4'd6, 4'd4);
      b = cas(b, 4'd4, 4'd2);
   end

   assign med = b[4];

endmodule

// File: rtl/disparity_median_filter.sv
// 3x3 median post-filter for the raster disparity stream; border pixels pass through.
// Latency: 2 cycles from the triggering accept/flush cycle; output lags input by WIDTH+1 pixels.
// Backpressure: in_ready drops only during the WIDTH+1 cycle end-of-frame flush; output cannot stall.
// Ports: HCLK, HRESET (async, active high), bus (slave side of disparity_median_filter_if).
module disparity_median_filter #(
   parameter int WIDTH  = stereo_pkg::WIDTH,
   parameter int HEIGHT = stereo_pkg::HEIGHT
) (
   input logic                      HCLK,
   input logic                      HRESET,
   disparity_median_filter_if.slave bus
);
   import stereo_pkg::*;

   localparam int CW = $clog2(WIDTH);
   localparam int RW = $clog2(HEIGHT + 2);   // row counter runs two past the frame during flush

   localparam logic [CW-1:0] COL_ONE   = CW'(1);
   localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
   localparam logic [RW-1:0] ROW_ONE   = RW'(1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);
   localparam logic [RW-1:0] ROW_FEND  = RW'(HEIGHT + 1);
   localparam addr_t         ADDR_LAST = ADDR_W'(WIDTH * HEIGHT - 1);

   state_t         state;
   state_t         state_nxt;
   logic           live_q;
   logic           in_rdy;
   logic           flush_step;

   logic [CW-1:0]  col;
   logic [RW-1:0]  row;
   logic [CW-1:0]  pcol;
   logic [RW-1:0]  prow;

   logic           acc;
   logic           resync;
   logic           step;
   logic           emit;

   disparity_t     lb1 [WIDTH];   // row r-1
   disparity_t     lb2 [WIDTH];   // row r-2
   disparity_t     lb1_rd;
   disparity_t     lb2_rd;
   disparity_t     pix_new;
   win9_t          win;
   win9_t          win_nxt;

   logic [CW-1:0]  cc;
   logic [RW-1:0]  cr;
   addr_t          optr;
   logic           border_c;

   logic           s1_vld;
   logic           s1_border;
   logic           s1_last;
   disparity_t     s1_centre;
   addr_t          s1_addr;
   disparity_t     med;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state  <= IDLE;
         live_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         live_q <= 1'b1;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (acc) state_nxt = FILL;
         FILL:  if (acc && !resync && prow == ROW_ONE && pcol == COL_ONE) state_nxt = RUN;
         RUN: begin
            if (resync)
               state_nxt = FILL;
            else if (acc && prow == ROW_LAST && pcol == COL_LAST)
               state_nxt = FLUSH;
         end
         FLUSH: if (prow == ROW_FEND) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // live_q keeps in_ready low while reset is applied and for the first cycle after
   always_comb begin
      in_rdy     = live_q && (state != FLUSH);
      flush_step = (state == FLUSH);
   end

   assign bus.in_ready = in_rdy;

   // ---------------- position and window ----------------
   assign acc    = bus.in_valid && in_rdy;
   assign resync = acc && (bus.in_addr == '0);
   assign step   = acc || flush_step;
   assign pcol   = resync ? '0 : col;
   assign prow   = resync ? '0 : row;

   assign lb1_rd  = lb1[pcol];
   assign lb2_rd  = lb2[pcol];
   // During flush the last row is replicated; only border centres are produced then
   assign pix_new = acc ? bus.in_data : lb1_rd;

   // Shift one column; across a row wrap the window mixes columns, but the middle
   // element of column 1 is always the pixel WIDTH+1 behind the newest one
   always_comb begin
      win_nxt        = win;
      win_nxt[2:0]   = win[5:3];
      win_nxt[5:3]   = win[8:6];
      win_nxt[6]     = lb2_rd;
      win_nxt[7]     = lb1_rd;
      win_nxt[8]     = pix_new;
   end

   // FILL emits from pixel (1,1) onward; a resync pixel is (0,0) of the new frame
   assign emit = step && !resync &&
                 (state == RUN || state == FLUSH ||
                  (state == FILL && prow == ROW_ONE && pcol == COL_ONE));

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         col <= '0;
         row <= '0;
         win <= '0;
      end else if (step) begin
         win <= win_nxt;
         if (flush_step && prow == ROW_FEND) begin
            col <= '0;
            row <= '0;
         end else if (pcol == COL_LAST) begin
            col <= '0;
            row <= prow + RW'(1);
         end else begin
            col <= pcol + CW'(1);
            row <= prow;
         end
      end
   end

   // Line buffer contents need no reset
   always_ff @(posedge HCLK) begin
      if (step) begin
         lb2[pcol] <= lb1_rd;
         lb1[pcol] <= pix_new;
      end
   end

   // ---------------- centre position of the next output ----------------
   assign border_c = (cr == '0) || (cr == ROW_LAST) || (cc == '0) || (cc == COL_LAST);

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         cc   <= '0;
         cr   <= '0;
         optr <= '0;
      end else if (resync) begin
         cc   <= '0;
         cr   <= '0;
         optr <= '0;
      end else if (emit) begin
         if (optr == ADDR_LAST) begin
            cc   <= '0;
            cr   <= '0;
            optr <= '0;
         end else begin
            optr <= optr + ADDR_W'(1);
            if (cc == COL_LAST) begin
               cc <= '0;
               cr <= cr + RW'(1);
            end else begin
               cc <= cc + CW'(1);
            end
         end
      end
   end

   // ---------------- pipeline ----------------
   median9_sort u_sort (
      .HCLK (HCLK),
      .pix  (win_nxt),
      .med  (med)
   );

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         s1_vld    <= 1'b0;
         s1_border <= 1'b0;
         s1_last   <= 1'b0;
         s1_centre <= '0;
         s1_addr   <= '0;
      end else begin
         s1_vld    <= emit;
         s1_border <= border_c;
         s1_last   <= (optr == ADDR_LAST);
         s1_centre <= win[7];
         s1_addr   <= optr;
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         bus.out_valid  <= 1'b0;
         bus.out_data   <= '0;
         bus.out_addr   <= '0;
         bus.frame_done <= 1'b0;
      end else begin
         bus.out_valid  <= s1_vld;
         bus.frame_done <= s1_vld && s1_last;
         if (s1_vld) begin
            bus.out_data <= s1_border ? s1_centre : med;
            bus.out_addr <= s1_addr;
         end
      end
   end

endmodule

// File: tb/tb_disparity_median_filter.sv
// Self-checking bench for disparity_median_filter on an 8x6 frame.
// Latency: checks every output against a software 3x3 median model in address order.
// Backpressure: stimulus waits on in_ready; each wait is bounded.
module tb_disparity_median_filter;
   import stereo_pkg::*;

   localparam int W = 8;
   localparam int H = 6;
   localparam int N = W * H;

   logic HCLK   = 1'b0;
   logic HRESET = 1'b1;

   disparity_median_filter_if bus();

   disparity_median_filter #(.WIDTH(W), .HEIGHT(H)) dut (
      .HCLK   (HCLK),
      .HRESET (HRESET),
      .bus    (bus)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      int addr;
      int data;
      bit last;
   } exp_t;

   exp_t expq[$];
   int   frm [N];
   int   got [N];
   int   nvec      = 0;
   int   nerr      = 0;
   int   lowcnt    = 0;
   int   first_low = 0;
   int   fdcnt     = 0;

   task automatic chk(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Golden model: border passthrough, otherwise sorted-neighbourhood median
   function automatic int gold(int a);
      int r = a / W;
      int c = a % W;
      int v[9];
      int k = 0;
      int t;
      if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return frm[a];
      for (int dr = -1; dr <= 1; dr++)
         for (int dc = -1; dc <= 1; dc++) begin
            v[k] = frm[(r + dr) * W + c + dc];
            k++;
         end
      for (int i = 0; i < 9; i++)
         for (int j = 0; j < 8 - i; j++)
            if (v[j] > v[j + 1]) begin
               t = v[j]; v[j] = v[j + 1]; v[j + 1] = t;
            end
      return v[4];
   endfunction

   // Output monitor / scoreboard
   initial begin
      exp_t e;
      bit   h1 = 1'b0;
      bit   h2 = 1'b0;
      forever begin
         @(negedge HCLK);
         if (HRESET) begin
            h1 = 1'b0;
            h2 = 1'b0;
         end else begin
            if (!bus.in_ready) lowcnt++;
            if (bus.out_valid) begin
               chk("out_has_trigger_2_cycles_earlier", int'(h2), 1);
               if (expq.size() == 0) begin
                  chk("spurious_output_addr", int'(bus.out_addr), -1);
               end else begin
                  e = expq.pop_front();
                  chk("out_addr", int'(bus.out_addr), e.addr);
                  chk($sformatf("out_data@%0d", e.addr), int'(bus.out_data), e.data);
                  chk($sformatf("frame_done@%0d", e.addr), int'(bus.frame_done), int'(e.last));
               end
               if (bus.frame_done) fdcnt++;
               if (int'(bus.out_addr) < N) got[bus.out_addr] = int'(bus.out_data);
            end else if (bus.frame_done) begin
               chk("frame_done_without_valid", 1, 0);
            end
            h2 = h1;
            h1 = (bus.in_valid && bus.in_ready) || !bus.in_ready;
         end
      end
   end

   task automatic send_pix(input int d, input int a, input bit gaps);
      bit ok;
      int guard = 0;
      if (gaps)
         for (int g = 0; g < 3; g++) begin
            if ($urandom_range(1, 0) == 0) break;
            bus.in_valid = 1'b0;
            @(posedge HCLK); #1;
         end
      bus.in_valid = 1'b1;
      bus.in_data  = DISP_W'(d);
      bus.in_addr  = ADDR_W'(a);
      forever begin
         @(negedge HCLK);
         ok = bus.in_ready;
         @(posedge HCLK); #1;
         if (ok) break;
         guard++;
         if (guard > 200) begin
            chk("in_ready_timeout", 0, 1);
            break;
         end
      end
      bus.in_valid = 1'b0;
   endtask

   // Queues the expected outputs the sent pixels will produce, then sends them
   task automatic send_frame(input int n, input bit gaps);
      int last_exp = (n >= N) ? N - 1 : n - W - 2;
      for (int a = 0; a <= last_exp; a++) expq.push_back('{a, gold(a), a == N - 1});
      for (int a = 0; a < n; a++) begin
         send_pix(frm[a], a, gaps);
         if (a == 0) first_low = lowcnt;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && expq.size() > 0; i++) @(posedge HCLK);
      @(posedge HCLK); #1;
      chk("outputs_still_pending", expq.size(), 0);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_addr  = '0;

      // Reset values
      @(negedge HCLK);
      chk("reset_in_ready",   int'(bus.in_ready),   0);
      chk("reset_out_valid",  int'(bus.out_valid),  0);
      chk("reset_out_data",   int'(bus.out_data),   0);
      chk("reset_out_addr",   int'(bus.out_addr),   0);
      chk("reset_frame_done", int'(bus.frame_done), 0);
      @(posedge HCLK); #1;
      HRESET = 1'b0;

      // Constant frame, then spike frame sent back-to-back (first pixel waits out the flush)
      for (int a = 0; a < N; a++) frm[a] = 5;
      send_frame(N, 1'b0);
      chk("model_const", gold(20), 5);
      lowcnt = 0;
      for (int a = 0; a < N; a++) frm[a] = 3;
      frm[19] = 15;
      send_frame(N, 1'b0);
      chk("flush_ready_low_cycles", first_low, W + 1);
      drain();
      chk("model_spike_interior", gold(19), 3);
      chk("dut_spike_interior", got[19], 3);

      // Spike on the top border passes through
      for (int a = 0; a < N; a++) frm[a] = 3;
      frm[4] = 15;
      send_frame(N, 1'b0);
      drain();
      chk("model_spike_border", gold(4), 15);
      chk("dut_spike_border", got[4], 15);
      for (int a = 11; a <= 13; a++) chk($sformatf("dut_below_border_spike@%0d", a), got[a], 3);

      // Ramp with random input gaps, then a random frame with gaps
      for (int a = 0; a < N; a++) frm[a] = a / W + a % W;
      send_frame(N, 1'b1);
      lowcnt = 0;
      chk("model_ramp", gold(27), 6);
      for (int a = 0; a < N; a++) frm[a] = $urandom_range(15, 0);
      send_frame(N, 1'b1);
      chk("flush_ready_low_cycles_gappy", first_low, W + 1);
      drain();

      // Reset after pixel 20: in-flight outputs discarded, then a clean frame
      for (int a = 0; a < N; a++) frm[a] = $urandom_range(15, 0);
      send_frame(20, 1'b0);
      HRESET = 1'b1;
      expq.delete();
      @(negedge HCLK);
      chk("mid_reset_out_valid", int'(bus.out_valid), 0);
      chk("mid_reset_in_ready",  int'(bus.in_ready),  0);
      @(posedge HCLK); #1;
      HRESET = 1'b0;
      repeat (4) @(posedge HCLK);
      #1;
      for (int a = 0; a < N; a++) frm[a] = $urandom_range(15, 0);
      send_frame(N, 1'b0);
      drain();

      // Early new frame (in_addr==0 during RUN): partial outputs still drain first
      for (int a = 0; a < N; a++) frm[a] = $urandom_range(15, 0);
      send_frame(20, 1'b0);
      for (int a = 0; a < N; a++) frm[a] = $urandom_range(15, 0);
      send_frame(N, 1'b0);
      drain();

      // Ramp output literals re-checked on a final gap-free ramp
      for (int a = 0; a < N; a++) frm[a] = a / W + a % W;
      send_frame(N, 1'b0);
      drain();
      chk("dut_ramp_19", got[19], 5);
      chk("dut_ramp_30", got[30], 9);
      chk("frame_done_count", fdcnt, 8);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
